// File: rtl/flexcounter_pkg.sv
// Shared types and defaults for the flexcounter controller.
package flexcounter_pkg;

  localparam int COUNTSIZE_DFLT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/flexcounter_if.sv
// Signal bundle between the interval controller and the flexcounter.
interface flexcounter_if #(
  parameter int COUNTWIDTH = 10
) ();

  logic                  nRST;
  logic                  enableCounter;
  logic [COUNTWIDTH-1:0] maxCount;
  logic                  strobe;
  logic [COUNTWIDTH-1:0] count;

  modport controller (
    output nRST, enableCounter, maxCount,
    input  strobe, count
  );

  modport counter (
    input  nRST, enableCounter, maxCount,
    output strobe, count
  );

endinterface

// File: rtl/flexcounter_ctrl.sv
// Runs a flexcounter for requested intervals (one-shot or periodic) and
// reports ticks, completion, aborts and the remaining count.
module flexcounter_ctrl
  import flexcounter_pkg::*;
#(
  parameter int COUNTSIZE  = COUNTSIZE_DFLT,
  parameter int COUNTWIDTH = $clog2(COUNTSIZE)
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [COUNTWIDTH-1:0] req_len,
  input  logic                  req_periodic,
  input  logic                  stop,
  output logic                  busy,
  output logic                  tick,
  output logic                  done,
  output logic                  aborted,
  output logic [COUNTWIDTH-1:0] remaining,
  output logic                  cnt_nRST,
  output logic                  cnt_enable,
  output logic [COUNTWIDTH-1:0] cnt_max,
  input  logic                  cnt_strobe,
  input  logic [COUNTWIDTH-1:0] cnt_count
);

  ctrl_state_t           state_q, state_d;
  logic [COUNTWIDTH-1:0] len_q, len_d;
  logic                  periodic_q, periodic_d;
  logic [COUNTWIDTH-1:0] cnt_max_q, cnt_max_d;
  logic [COUNTWIDTH-1:0] remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  cnt_nrst_q, cnt_nrst_d;
  logic                  cnt_enable_q, cnt_enable_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    periodic_d = periodic_q;
    cnt_max_d  = cnt_max_q;
    tick_d     = 1'b0;
    aborted_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          len_d      = req_len;
          periodic_d = req_periodic;
          cnt_max_d  = req_len;
          state_d    = (req_len == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        aborted_d = stop;
        state_d   = stop ? IDLE : RUN;
      end
      RUN: begin
        // A strobe coinciding with stop completes the interval rather than aborting it.
        if (cnt_strobe) begin
          tick_d = 1'b1;
          if (!periodic_q || stop) state_d = DONE;
        end else if (stop) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    cnt_enable_d = (state_d == RUN);
    cnt_nrst_d   = (state_d != CLEAR);
    remaining_d  = '0;
    if (state_d == RUN)
      remaining_d = (cnt_count > len_q) ? '0 : (len_q - cnt_count);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      len_q        <= '0;
      periodic_q   <= 1'b0;
      cnt_max_q    <= '0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cnt_nrst_q   <= 1'b0;
      cnt_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      periodic_q   <= periodic_d;
      cnt_max_q    <= cnt_max_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cnt_nrst_q   <= cnt_nrst_d;
      cnt_enable_q <= cnt_enable_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = busy_q;
  assign tick       = tick_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign remaining  = remaining_q;
  assign cnt_nRST   = cnt_nrst_q;
  assign cnt_enable = cnt_enable_q;
  assign cnt_max    = cnt_max_q;

endmodule

// File: tb/tb_flexcounter_ctrl.sv
// Bench for flexcounter_ctrl driving a behavioural flexcounter; a timeline
// model predicts every output each cycle, plus directed literal checks.
module tb_flexcounter_ctrl;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          nRST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_periodic = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] req_len = '0;
  logic          req_ready, busy, tick, done, aborted;
  logic [CW-1:0] remaining;

  flexcounter_if #(.COUNTWIDTH(CW)) fc ();

  always #5 clk = ~clk;

  flexcounter_ctrl #(.COUNTSIZE(1024)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_len      (req_len),
    .req_periodic (req_periodic),
    .stop         (stop),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .aborted      (aborted),
    .remaining    (remaining),
    .cnt_nRST     (fc.nRST),
    .cnt_enable   (fc.enableCounter),
    .cnt_max      (fc.maxCount),
    .cnt_strobe   (fc.strobe),
    .cnt_count    (fc.count)
  );

  // Behavioural flexcounter: counts 1..maxCount while enabled, then wraps to 1.
  logic [CW-1:0] fc_cnt;
  always @(posedge clk or negedge fc.nRST) begin
    if (!fc.nRST) fc_cnt <= '0;
    else if (fc.enableCounter) fc_cnt <= (fc_cnt == fc.maxCount) ? CW'(1) : fc_cnt + CW'(1);
  end
  assign fc.count  = fc_cnt;
  assign fc.strobe = fc.enableCounter && (fc_cnt == fc.maxCount);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // m_k = cycles since the accepting edge (1 = clear cycle, >=2 counting), 0 = none.
  int  m_k = 0, m_L = 0;
  bit  m_P = 0, m_dc = 0;
  logic          e_busy, e_tick, e_done, e_abort, e_nrst, e_en;
  logic [CW-1:0] e_rem, e_max;

  function automatic int cnt_at(input int k, input int L);
    if (k <= 2 || L == 0) return 0;
    return ((k - 3) % L) + 1;
  endfunction

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      m_k = 0; m_dc = 0; m_L = 0; m_P = 0;
      e_busy = 0; e_tick = 0; e_done = 0; e_abort = 0;
      e_nrst = 0; e_en = 0; e_rem = '0; e_max = '0;
    end else begin
      e_tick = 0; e_abort = 0;
      if (m_dc) m_dc = 0;
      else if (m_k == 0) begin
        if (req_valid) begin
          m_L = int'(req_len); m_P = req_periodic; e_max = req_len;
          if (m_L == 0) m_dc = 1; else m_k = 1;
        end
      end else if (m_k >= 2 && cnt_at(m_k, m_L) == m_L) begin
        e_tick = 1;
        if (!m_P || stop) begin m_k = 0; m_dc = 1; end
        else m_k++;
      end else if (stop) begin
        e_abort = 1; m_k = 0;
      end else m_k++;
      e_done = m_dc;
      e_busy = m_dc || (m_k != 0);
      e_nrst = (m_k != 1);
      e_en   = (m_k >= 2);
      e_rem  = (m_k >= 2) ? CW'(m_L - cnt_at(m_k - 1, m_L)) : '0;
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int ncyc = 0, acc_cyc = -1, done_cyc = -1;
  int n_tick = 0, n_done = 0, n_abort = 0, n_en = 0;
  int tick_q[$];

  always @(negedge clk) begin
    ncyc++;
    if (req_valid && req_ready) acc_cyc = ncyc;
    if (done) begin done_cyc = ncyc; n_done++; end
    if (tick) begin tick_q.push_back(ncyc); n_tick++; end
    if (aborted) n_abort++;
    if (fc.enableCounter) n_en++;
    chk("req_ready",  32'(req_ready),        32'(!e_busy));
    chk("busy",       32'(busy),             32'(e_busy));
    chk("tick",       32'(tick),             32'(e_tick));
    chk("done",       32'(done),             32'(e_done));
    chk("aborted",    32'(aborted),          32'(e_abort));
    chk("remaining",  32'(remaining),        32'(e_rem));
    chk("cnt_nRST",   32'(fc.nRST),          32'(e_nrst));
    chk("cnt_enable", 32'(fc.enableCounter), 32'(e_en));
    chk("cnt_max",    32'(fc.maxCount),      32'(e_max));
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input int len, input bit per);
    bit ok = 0;
    @(posedge clk); #2;
    req_len = CW'(len); req_periodic = per; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    chk("req_accept_timeout", 32'(ok), 32'(1));
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1; break; end
    end
    chk("done_timeout", 32'(ok), 32'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),        32'(1));
    chk({tag, "_busy"},       32'(busy),             32'(0));
    chk({tag, "_tick"},       32'(tick),             32'(0));
    chk({tag, "_done"},       32'(done),             32'(0));
    chk({tag, "_aborted"},    32'(aborted),          32'(0));
    chk({tag, "_remaining"},  32'(remaining),        32'(0));
    chk({tag, "_cnt_nRST"},   32'(fc.nRST),          32'(0));
    chk({tag, "_cnt_enable"}, 32'(fc.enableCounter), 32'(0));
    chk({tag, "_cnt_max"},    32'(fc.maxCount),      32'(0));
  endtask

  initial begin
    int t0, d0, a0, e0, ti;
    bit ok;

    // Reset
    #1 nRST = 1'b0;
    #1 chk_reset_values("reset");
    repeat (2) @(posedge clk);
    #2 nRST = 1'b1;
    idle(2);
    $display("txn reset: released, req_ready=%0d", req_ready);

    // One-shot, len=5: done lands 1 + 5 + 1 edges after the accepting edge
    t0 = n_tick;
    do_req(5, 0);
    wait_done(40);
    chk("oneshot_latency", 32'(done_cyc - acc_cyc - 1), 32'(7));
    chk("oneshot_tick_with_done", 32'(tick_q[$]), 32'(done_cyc));
    chk("oneshot_ticks", 32'(n_tick - t0), 32'(1));
    idle(1);
    chk("oneshot_busy_falls", 32'(busy), 32'(0));
    $display("txn oneshot len=5: accepted@%0d done@%0d", acc_cyc, done_cyc);
    idle(2);

    // Periodic, len=3, stop after the third tick
    t0 = n_tick; d0 = n_done; a0 = n_abort; ti = tick_q.size();
    do_req(3, 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (n_tick - t0 >= 3) begin ok = 1; break; end
    end
    chk("periodic_three_ticks", 32'(ok), 32'(1));
    if (ok) begin
      chk("periodic_spacing1", 32'(tick_q[ti+1] - tick_q[ti]),   32'(3));
      chk("periodic_spacing2", 32'(tick_q[ti+2] - tick_q[ti+1]), 32'(3));
    end
    stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
    idle(2);
    chk("periodic_aborted", 32'(n_abort - a0), 32'(1));
    chk("periodic_no_done", 32'(n_done - d0),  32'(0));
    chk("periodic_enable_off", 32'(fc.enableCounter), 32'(0));
    $display("txn periodic len=3: ticks=%0d aborts=%0d", n_tick - t0, n_abort - a0);
    idle(2);

    // Zero length
    t0 = n_tick; e0 = n_en;
    do_req(0, 0);
    wait_done(10);
    chk("zero_done_next_cycle", 32'(done_cyc - acc_cyc), 32'(1));
    idle(2);
    chk("zero_no_tick",   32'(n_tick - t0), 32'(0));
    chk("zero_no_enable", 32'(n_en - e0),   32'(0));
    $display("txn zero len: accepted@%0d done@%0d", acc_cyc, done_cyc);
    idle(2);

    // Stop coincident with strobe, periodic len=4
    t0 = n_tick; d0 = n_done; a0 = n_abort;
    do_req(4, 1);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fc.strobe) begin ok = 1; break; end
    end
    chk("coincident_strobe_seen", 32'(ok), 32'(1));
    stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
    idle(2);
    chk("coincident_tick",    32'(n_tick - t0),  32'(1));
    chk("coincident_done",    32'(n_done - d0),  32'(1));
    chk("coincident_aborted", 32'(n_abort - a0), 32'(0));
    chk("coincident_idle",    32'(req_ready),    32'(1));
    $display("txn stop+strobe len=4: tick=%0d done=%0d aborted=%0d",
             n_tick - t0, n_done - d0, n_abort - a0);
    idle(2);

    // Back-to-back: req_valid held, len=2 then len=7
    @(posedge clk); #2;
    req_len = CW'(2); req_periodic = 1'b0; req_valid = 1'b1;
    @(posedge clk); #2;
    req_len = CW'(7);
    wait_done(20);
    chk("b2b_ready_low_in_done", 32'(req_ready),   32'(0));
    chk("b2b_max_first",         32'(fc.maxCount), 32'(2));
    idle(1);
    chk("b2b_ready_after_done",  32'(req_ready),   32'(1));
    chk("b2b_max_before_accept", 32'(fc.maxCount), 32'(2));
    @(posedge clk); #2 req_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b_max_second", 32'(fc.maxCount), 32'(7));
    chk("b2b_clear_pulse", 32'(fc.nRST),    32'(0));
    wait_done(30);
    chk("b2b_second_latency", 32'(done_cyc - acc_cyc - 1), 32'(9));
    $display("txn back-to-back len=2,7: second accepted@%0d done@%0d", acc_cyc, done_cyc);
    idle(2);

    // Reset in the middle of a long run
    do_req(100, 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fc.count == CW'(40)) begin ok = 1; break; end
    end
    chk("midrun_reached_40", 32'(ok), 32'(1));
    #1 nRST = 1'b0;
    #1 chk_reset_values("midrun");
    chk("midrun_counter_cleared", 32'(fc.count), 32'(0));
    @(posedge clk); #2 nRST = 1'b1;
    idle(1);
    chk("midrun_ready",     32'(req_ready), 32'(1));
    chk("midrun_remaining", 32'(remaining), 32'(0));
    chk("midrun_busy",      32'(busy),      32'(0));
    $display("txn reset mid-run len=100: ready=%0d remaining=%0d", req_ready, remaining);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flexcounter_ctrl.md
Name: flexcounter_ctrl

Overview:
- Controller-side driver for the flexcounter interface. It owns the counter's nRST, enableCounter and maxCount, and consumes strobe and count.
- Accepts interval requests over a valid/ready handshake and runs the counter for the requested length, one-shot or periodic.
- Reports ticks, completion and remaining count to the client logic, e.g. key-repeat and character-timing in the typing datapath.

Parameters:
- COUNTSIZE, 1024, counter range; must match the attached flexcounter
- COUNTWIDTH, $clog2(COUNTSIZE), width of count/maxCount/req_len

Ports:
- clk  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- req_valid  input  1  interval request present
- req_ready  output  1  high only in IDLE
- req_len  input  COUNTWIDTH  interval length, loaded as maxCount
- req_periodic  input  1  1 = repeat until stop, 0 = one-shot
- stop  input  1  abort or end the current interval
- busy  output  1  state != IDLE
- tick  output  1  one-cycle pulse per completed interval
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  one-cycle pulse when stop ends an interval
- remaining  output  COUNTWIDTH  latched len minus cnt_count while RUN, else 0
- cnt_nRST  output  1  drives flexcounter nRST
- cnt_enable  output  1  drives flexcounter enableCounter
- cnt_max  output  COUNTWIDTH  drives flexcounter maxCount
- cnt_strobe  input  1  flexcounter strobe
- cnt_count  input  COUNTWIDTH  flexcounter count

Behaviour:
- Reset is asynchronous and active-low; the design uses one clock.
- Reset values:
  - state IDLE, req_ready 1
  - cnt_nRST 0, cnt_enable 0, cnt_max 0
  - busy, tick, done, aborted 0
  - remaining 0
- All outputs except req_ready are registered.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - cnt_enable 0, cnt_nRST 1.
  - Handshake fires when req_valid && req_ready; this latches len and periodic and drives cnt_max <= req_len.
  - If req_len == 0: go to DONE (zero-length interval) and never enable the counter.
  - Otherwise go to CLEAR.
- CLEAR:
  - Exactly one cycle with cnt_nRST 0 and cnt_enable 0, which zeroes the counter. Then go to RUN.
- RUN:
  - cnt_nRST 1, cnt_enable 1, cnt_max held stable.
  - On cnt_strobe: tick is 1 on the next cycle.
  - If periodic && !stop: stay in RUN; the counter wraps itself.
  - Otherwise go to DONE.
- DONE:
  - done 1 for exactly one cycle, cnt_enable 0. Then go to IDLE.
  - Latency: handshake to done = 1 (CLEAR) + len counter cycles + 1 (DONE).
- stop:
  - In RUN without a simultaneous strobe: go to IDLE with cnt_enable 0 and aborted pulsed. No tick, no done.
  - In RUN with a simultaneous strobe: the strobe wins; tick and done are pulsed, aborted is not, and periodic mode terminates.
  - In CLEAR: go to IDLE with aborted pulsed.
  - In IDLE or DONE: ignored.
- Requests are never accepted outside IDLE. A request on the same cycle as a DONE→IDLE transition is accepted on the following cycle.
- cnt_strobe outside RUN is ignored.
- remaining:
  - Computed as len - cnt_count, registered.
  - Saturates at 0 if cnt_count > len, which can only happen if the counter is misconfigured.
- Asynchronous reset mid-interval returns immediately to reset values; cnt_nRST 0 holds the counter cleared.

Decomposition:
- Package flexcounter_pkg holds:
  - the ctrl_state_t enum {IDLE, CLEAR, RUN, DONE}
  - the default COUNTSIZE constant
- No sub-module is needed. The testbench instantiates flexcounter_ctrl plus a flexcounter through flexcounter_if, using the controller modport on this side.

Test Plan:
- One-shot, len=5: req_valid with periodic=0 → req_ready drops; cnt_nRST is 0 for 1 cycle; cnt_max=5; tick and done assert together 1 cycle after strobe; busy falls next cycle.
- Periodic, len=3, stop after the third tick: three tick pulses with equal spacing, then stop → aborted=1; no done; cnt_enable=0.
- Zero length, len=0: done one cycle after acceptance; cnt_enable never 1; tick never 1.
- stop coincident with cnt_strobe in periodic, len=4: tick=1, done=1, aborted=0; controller returns to IDLE.
- Back-to-back: req_valid held high through done, len=2 then len=7 → second request accepted only once req_ready=1; cnt_max updates to 7 only after that acceptance; CLEAR pulse precedes second run.
- Reset mid-RUN, len=100, nRST low at count=40: all outputs at reset values immediately (asynchronously); after release, IDLE with req_ready=1 and remaining=0.
